// File: rtl/fb_access_arbiter.sv
// Frame-buffer access arbiter: sequences one camera frame capture from the pixel FIFO into RAM
// while sharing the single RAM port with the colour-sampler reader. Option: FB_DOUBLE_BUFFER_EN.
module fb_access_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int FRAME_PIXELS = 19200,
  parameter int MAX_WR_BURST = 8,
  parameter int RD_LATENCY   = 1
) (
  input  logic              clk_25MHz_i,
  input  logic              rst_n_i,
  input  logic              cap_start_i,
  output logic              cap_busy_o,
  output logic              cap_done_o,
  input  logic              f_d_available_i,
  input  logic [15:0]       f_r_data_i,
  output logic              f_r_en_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_gnt_o,
  output logic [15:0]       rd_data_o,
  output logic              rd_valid_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [15:0]       m_wdata_o,
  output logic              m_we_o,
  output logic              m_bank_o,
  input  logic [15:0]       m_rdata_i
);

  localparam int BW = $clog2(MAX_WR_BURST + 1);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [BW-1:0]     BURST_MAX = BW'(MAX_WR_BURST);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [BW-1:0]       burstCnt_q, burstCnt_d;
  logic [RD_LATENCY:0] rdPipe_q, rdPipe_d;
  logic [ADDR_W-1:0]   mAddr_q, mAddr_d;
  logic [15:0]         mWdata_q, mWdata_d;
  logic                mWe_q, mWe_d;
  logic                mBank_q, mBank_d;
  logic                writeCand, wrGnt, rdGnt, flush, capBusy, capDone;
  logic                writeBank, readBank;

`ifdef FB_DOUBLE_BUFFER_EN
  // The sampler always reads the bank holding the last complete frame.
  logic wBank_q;
  always_ff @(posedge clk_25MHz_i) begin
    if (!rst_n_i) begin
      wBank_q <= 1'b0;
    end else if (state_q == DONE) begin
      wBank_q <= ~wBank_q;
    end
  end
  assign writeBank = wBank_q;
  assign readBank  = ~wBank_q;
`else
  assign writeBank = 1'b0;
  assign readBank  = 1'b0;
`endif

  always_ff @(posedge clk_25MHz_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wrGnt     = 1'b0;
    rdGnt     = 1'b0;
    flush     = 1'b0;
    capBusy   = 1'b0;
    capDone   = 1'b0;
    writeCand = (state_q == CAPTURE) && f_d_available_i;

    // Writer wins unless it has already starved a pending read for a full burst.
    if (rd_req_i && (!writeCand || (burstCnt_q == BURST_MAX))) begin
      rdGnt = 1'b1;
    end else if (writeCand) begin
      wrGnt = 1'b1;
    end

    case (state_q)
      IDLE: begin
        flush = f_d_available_i;
        if (cap_start_i) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        capBusy = 1'b1;
        if (wrGnt && (wrPtr_q == LAST_PTR)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        capDone = 1'b1;
        flush   = f_d_available_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    burstCnt_d = burstCnt_q;
    rdPipe_d   = '0;
    mAddr_d    = mAddr_q;
    mWdata_d   = mWdata_q;
    mBank_d    = mBank_q;
    mWe_d      = wrGnt;

    if ((state_q == IDLE) && cap_start_i) begin
      wrPtr_d = '0;
    end else if (wrGnt) begin
      wrPtr_d = wrPtr_q + ADDR_W'(1);
    end

    if (!rd_req_i || rdGnt) begin
      burstCnt_d = '0;
    end else if (wrGnt && (burstCnt_q != BURST_MAX)) begin
      burstCnt_d = burstCnt_q + BW'(1);
    end

    if (wrGnt) begin
      mAddr_d  = wrPtr_q;
      mWdata_d = f_r_data_i;
      mBank_d  = writeBank;
    end else if (rdGnt) begin
      mAddr_d  = rd_addr_i;
      mBank_d  = readBank;
    end

    // Stage 0 marks the cycle the read address is on the RAM port.
    rdPipe_d[0] = rdGnt;
    for (int i = 1; i <= RD_LATENCY; i++) begin
      rdPipe_d[i] = rdPipe_q[i-1];
    end
  end

  always_ff @(posedge clk_25MHz_i) begin
    if (!rst_n_i) begin
      wrPtr_q    <= '0;
      burstCnt_q <= '0;
      rdPipe_q   <= '0;
      mAddr_q    <= '0;
      mWdata_q   <= '0;
      mWe_q      <= 1'b0;
      mBank_q    <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      burstCnt_q <= burstCnt_d;
      rdPipe_q   <= rdPipe_d;
      mAddr_q    <= mAddr_d;
      mWdata_q   <= mWdata_d;
      mWe_q      <= mWe_d;
      mBank_q    <= mBank_d;
    end
  end

  assign cap_busy_o = rst_n_i & capBusy;
  assign cap_done_o = rst_n_i & capDone;
  assign f_r_en_o   = rst_n_i & (wrGnt | flush);
  assign rd_gnt_o   = rst_n_i & rdGnt;
  assign rd_valid_o = rdPipe_q[RD_LATENCY];
  assign rd_data_o  = (rst_n_i && rdPipe_q[RD_LATENCY]) ? m_rdata_i : 16'h0000;
  assign m_addr_o   = mAddr_q;
  assign m_wdata_o  = mWdata_q;
  assign m_we_o     = mWe_q;
  assign m_bank_o   = mBank_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed testbench for fb_access_arbiter with a small counting FIFO and an address-echo RAM.
// Bank expectations follow FB_DOUBLE_BUFFER_EN when it is defined.
module tb_fb_access_arbiter;

  localparam int ADDR_W       = 15;
  localparam int FRAME_PIXELS = 16;
  localparam int MAX_WR_BURST = 4;
  localparam int RD_LATENCY   = 1;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam logic DB = 1'b1;
`else
  localparam logic DB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, cap_start, f_d_available, rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       fifoData = 16'h0000;
  logic [15:0]       m_rdata  = 16'h0000;
  logic              cap_busy, cap_done, f_r_en, rd_gnt, rd_valid, m_we, m_bank;
  logic [15:0]       rd_data, m_wdata;
  logic [ADDR_W-1:0] m_addr;

  int checks = 0;
  int fails  = 0;

  fb_access_arbiter #(
    .ADDR_W(ADDR_W), .FRAME_PIXELS(FRAME_PIXELS),
    .MAX_WR_BURST(MAX_WR_BURST), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk_25MHz_i(clk), .rst_n_i(rst_n), .cap_start_i(cap_start),
    .cap_busy_o(cap_busy), .cap_done_o(cap_done),
    .f_d_available_i(f_d_available), .f_r_data_i(fifoData), .f_r_en_o(f_r_en),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_we_o(m_we), .m_bank_o(m_bank),
    .m_rdata_i(m_rdata)
  );

  always #20 clk = ~clk;

  // FIFO head counts up on each pop; RAM returns 0xC000 | address one cycle later.
  always @(posedge clk) begin
    if (f_r_en) fifoData <= fifoData + 16'd1;
    m_rdata <= 16'hC000 | {1'b0, m_addr};
  end

  int cyc = 0, doneCnt = 0, busyCnt = 0, popCnt = 0, gntCnt = 0, validCnt = 0;
  logic [ADDR_W-1:0] wrAddrQ[$];
  logic [15:0]       wrDataQ[$];
  logic              wrBankQ[$];
  logic [15:0]       validDataQ[$];
  int                traceQ[$];
  int                gntCycQ[$];
  int                validCycQ[$];

  always @(negedge clk) begin
    cyc++;
    if (m_we) begin
      wrAddrQ.push_back(m_addr);
      wrDataQ.push_back(m_wdata);
      wrBankQ.push_back(m_bank);
    end
    if (cap_done) doneCnt++;
    if (cap_busy) busyCnt++;
    if (f_r_en) popCnt++;
    if (cap_busy && f_r_en) traceQ.push_back(1);
    if (rd_gnt) begin
      gntCnt++;
      gntCycQ.push_back(cyc);
      traceQ.push_back(2);
    end
    if (rd_valid) begin
      validCnt++;
      validCycQ.push_back(cyc);
      validDataQ.push_back(rd_data);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic rstN, input logic capStart, input logic avail,
                               input logic rdReq, input logic [ADDR_W-1:0] rdAddr);
    @(posedge clk);
    #1;
    rst_n         = rstN;
    cap_start     = capStart;
    f_d_available = avail;
    rd_req        = rdReq;
    rd_addr       = rdAddr;
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int w0, b0, d0, p0, t0, g0, v0;
    rst_n = 1'b0; cap_start = 1'b0; f_d_available = 1'b0; rd_req = 1'b0; rd_addr = '0;

    // Reset with live requests: combinational outputs forced low, registers cleared.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 15'h0010);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 15'h0010);
    checkOutput("rst_f_r_en",    32'(f_r_en),    32'h0);
    checkOutput("rst_rd_gnt",    32'(rd_gnt),    32'h0);
    checkOutput("rst_cap_busy",  32'(cap_busy),  32'h0);
    checkOutput("rst_cap_done",  32'(cap_done),  32'h0);
    checkOutput("rst_rd_valid",  32'(rd_valid),  32'h0);
    checkOutput("rst_rd_data",   32'(rd_data),   32'h0);
    checkOutput("rst_m_we",      32'(m_we),      32'h0);
    checkOutput("rst_m_addr",    32'(m_addr),    32'h0);
    checkOutput("rst_m_wdata",   32'(m_wdata),   32'h0);
    checkOutput("rst_m_bank",    32'(m_bank),    32'h0);
    idleCycles(1);

    // Full frame: data 0..15 to addresses 0..15.
    w0 = wrAddrQ.size(); b0 = busyCnt; d0 = doneCnt;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("t1_busy_at_start", 32'(cap_busy), 32'h0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
    idleCycles(3);
    checkOutput("t1_write_count", 32'(wrAddrQ.size() - w0), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (w0 + i < wrAddrQ.size()) begin
        checkOutput($sformatf("t1_addr%0d", i), 32'(wrAddrQ[w0+i]), 32'(i));
        checkOutput($sformatf("t1_data%0d", i), 32'(wrDataQ[w0+i]), 32'(i));
        checkOutput($sformatf("t1_bank%0d", i), 32'(wrBankQ[w0+i]), 32'h0);
      end
    end
    checkOutput("t1_busy_cycles", 32'(busyCnt - b0), 32'd16);
    checkOutput("t1_done_pulses", 32'(doneCnt - d0), 32'd1);
    checkOutput("t1_idle_after",  32'(cap_busy),     32'h0);

    // Idle flush: five pops, no RAM writes; then one read of the completed frame.
    w0 = wrAddrQ.size(); p0 = popCnt;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
    idleCycles(1);
    checkOutput("t2_pops",   32'(popCnt - p0),           32'd5);
    checkOutput("t2_writes", 32'(wrAddrQ.size() - w0),   32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 15'h0004);
    checkOutput("t2_rd_gnt",  32'(rd_gnt), 32'h1);
    checkOutput("t2_no_pop",  32'(f_r_en), 32'h0);
    idleCycles(1);
    checkOutput("t2_m_we",    32'(m_we),    32'h0);
    checkOutput("t2_m_addr",  32'(m_addr),  32'h4);
    checkOutput("t2_m_wdata_hold", 32'(m_wdata), 32'hF);
    checkOutput("t2_rd_bank", 32'(m_bank),  32'h0);
    idleCycles(1);
    checkOutput("t2_rd_valid", 32'(rd_valid), 32'h1);
    checkOutput("t2_rd_data",  32'(rd_data),  32'hC004);
    idleCycles(2);

    // Read held through a capture: four writes then one read, repeating.
    w0 = wrAddrQ.size(); d0 = doneCnt; t0 = traceQ.size(); g0 = gntCycQ.size(); v0 = validCycQ.size();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 19; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 15'h0005);
    idleCycles(3);
    checkOutput("t3_trace_len", 32'(traceQ.size() - t0), 32'd19);
    for (int i = 0; i < 19; i++) begin
      if (t0 + i < traceQ.size())
        checkOutput($sformatf("t3_grant%0d", i), 32'(traceQ[t0+i]), (i % 5 == 4) ? 32'd2 : 32'd1);
    end
    checkOutput("t3_read_grants", 32'(gntCycQ.size() - g0),   32'd3);
    checkOutput("t3_read_valids", 32'(validCycQ.size() - v0), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if ((g0 + k < gntCycQ.size()) && (v0 + k < validCycQ.size())) begin
        checkOutput($sformatf("t3_valid_delay%0d", k),
                    32'(validCycQ[v0+k] - gntCycQ[g0+k]), 32'(1 + RD_LATENCY));
        checkOutput($sformatf("t3_valid_data%0d", k), 32'(validDataQ[v0+k]), 32'hC005);
      end
    end
    checkOutput("t3_write_count", 32'(wrAddrQ.size() - w0), 32'd16);
    if (wrAddrQ.size() - w0 == 16) begin
      checkOutput("t3_first_addr", 32'(wrAddrQ[w0]),      32'h0);
      checkOutput("t3_last_addr",  32'(wrAddrQ[w0+15]),   32'hF);
      checkOutput("t3_wr_bank",    32'(wrBankQ[w0+15]),   32'(DB));
    end
    checkOutput("t3_done_pulses", 32'(doneCnt - d0), 32'd1);

    // Reset at the 7th pixel, one cycle after a read grant.
    d0 = doneCnt; v0 = validCycQ.size();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 15'h0009);
    checkOutput("t4_rd_gnt",   32'(rd_gnt),   32'h1);
    checkOutput("t4_busy",     32'(cap_busy), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 15'h0009);
    checkOutput("t4_rst_f_r_en",  32'(f_r_en),   32'h0);
    checkOutput("t4_rst_rd_gnt",  32'(rd_gnt),   32'h0);
    checkOutput("t4_rst_busy",    32'(cap_busy), 32'h0);
    checkOutput("t4_rst_valid",   32'(rd_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 15'h0009);
    checkOutput("t4_rst_m_we",    32'(m_we),     32'h0);
    checkOutput("t4_rst_m_addr",  32'(m_addr),   32'h0);
    checkOutput("t4_rst_m_wdata", 32'(m_wdata),  32'h0);
    checkOutput("t4_rst_m_bank",  32'(m_bank),   32'h0);
    checkOutput("t4_rst_valid2",  32'(rd_valid), 32'h0);
    idleCycles(3);
    checkOutput("t4_no_valid", 32'(validCycQ.size() - v0), 32'd0);
    checkOutput("t4_no_done",  32'(doneCnt - d0),          32'd0);
    w0 = wrAddrQ.size(); d0 = doneCnt;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
    idleCycles(3);
    checkOutput("t4_refill_count", 32'(wrAddrQ.size() - w0), 32'd16);
    if (wrAddrQ.size() - w0 == 16) begin
      checkOutput("t4_refill_first", 32'(wrAddrQ[w0]),    32'h0);
      checkOutput("t4_refill_last",  32'(wrAddrQ[w0+15]), 32'hF);
      checkOutput("t4_refill_bank",  32'(wrBankQ[w0]),    32'h0);
    end
    checkOutput("t4_refill_done", 32'(doneCnt - d0), 32'd1);

    // cap_start and rd_req together in IDLE; a second cap_start mid-capture is ignored.
    w0 = wrAddrQ.size(); b0 = busyCnt; d0 = doneCnt;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 15'h0003);
    checkOutput("t5_rd_gnt",     32'(rd_gnt),   32'h1);
    checkOutput("t5_flush_pop",  32'(f_r_en),   32'h1);
    checkOutput("t5_busy0",      32'(cap_busy), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
    checkOutput("t5_rd_gnt1",    32'(rd_gnt),   32'h0);
    checkOutput("t5_wr_pop",     32'(f_r_en),   32'h1);
    checkOutput("t5_busy1",      32'(cap_busy), 32'h1);
    checkOutput("t5_rd_m_we",    32'(m_we),     32'h0);
    checkOutput("t5_rd_m_addr",  32'(m_addr),   32'h3);
    checkOutput("t5_rd_bank",    32'(m_bank),   32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
    checkOutput("t5_wr_m_we",    32'(m_we),     32'h1);
    checkOutput("t5_wr_m_addr",  32'(m_addr),   32'h0);
    checkOutput("t5_wr_bank",    32'(m_bank),   32'(DB));
    checkOutput("t5_rd_valid",   32'(rd_valid), 32'h1);
    checkOutput("t5_rd_data",    32'(rd_data),  32'hC003);
    for (int i = 0; i < 18; i++) applyStimulus(1'b1, (i == 2), 1'b1, 1'b0, '0);
    idleCycles(3);
    checkOutput("t5_done_pulses", 32'(doneCnt - d0),         32'd1);
    checkOutput("t5_busy_cycles", 32'(busyCnt - b0),         32'd16);
    checkOutput("t5_write_count", 32'(wrAddrQ.size() - w0),  32'd16);

    // Read at the top address after the frame completes.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 15'h7FFF);
    checkOutput("t6_rd_gnt",   32'(rd_gnt),   32'h1);
    idleCycles(1);
    checkOutput("t6_m_addr",   32'(m_addr),   32'h7FFF);
    checkOutput("t6_m_bank",   32'(m_bank),   32'(DB));
    checkOutput("t6_m_we",     32'(m_we),     32'h0);
    idleCycles(1);
    checkOutput("t6_rd_valid", 32'(rd_valid), 32'h1);
    checkOutput("t6_rd_data",  32'(rd_data),  32'hFFFF);
    idleCycles(1);
    checkOutput("t6_single_valid", 32'(rd_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
